// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types and opcode tables for the multi-word ALU sequencer.
//   seq_op_e       : sequence operation requested on req_op (ADD, SUB, AND, XOR)
//   state_e        : sequencer FSM states
//   ALU_* opcodes  : 4-bit codes driven on alu_operation (ALU_NOP when idle)
//   first_opcode   : opcode for word 0 of a sequence
//   chain_opcode   : carry-propagating opcode for words 1..len
//   op_keeps_carry : whether the final ALU carry is reported on rsp_carry
package alu_seq_pkg;

    typedef enum logic [1:0] {
        SEQ_ADD = 2'd0,
        SEQ_SUB = 2'd1,
        SEQ_AND = 2'd2,
        SEQ_XOR = 2'd3
    } seq_op_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_e;

    localparam logic [3:0] ALU_NOP = 4'h0;
    localparam logic [3:0] ALU_ADD = 4'h1;  // a + b
    localparam logic [3:0] ALU_ADC = 4'h2;  // a + b + carry
    localparam logic [3:0] ALU_SUB = 4'h3;  // a - b, carry = borrow
    localparam logic [3:0] ALU_SBC = 4'h4;  // a - b - borrow
    localparam logic [3:0] ALU_AND = 4'h5;
    localparam logic [3:0] ALU_XOR = 4'h6;

    function automatic logic [3:0] first_opcode(input seq_op_e op);
        case (op)
            SEQ_ADD: return ALU_ADD;
            SEQ_SUB: return ALU_SUB;
            SEQ_AND: return ALU_AND;
            SEQ_XOR: return ALU_XOR;
            default: return ALU_NOP;
        endcase
    endfunction

    function automatic logic [3:0] chain_opcode(input seq_op_e op);
        case (op)
            SEQ_ADD: return ALU_ADC;
            SEQ_SUB: return ALU_SBC;
            SEQ_AND: return ALU_AND;
            SEQ_XOR: return ALU_XOR;
            default: return ALU_NOP;
        endcase
    endfunction

    // Bitwise ops have no meaningful carry; their rsp_carry is forced low.
    function automatic logic op_keeps_carry(input seq_op_e op);
        return (op == SEQ_ADD) || (op == SEQ_SUB);
    endfunction

endpackage

// File: rtl/alu_seq.sv
// alu_seq: sequences a multi-word (little-endian) operation through an external
// single-word ALU, one word per ISSUE/CAPTURE pair, and returns the full result.
//
// Optional feature macro: ALU_SEQ_ZERO_FLAG_EN
//   defined   -> rsp_zero = 1 when every captured word 0..len is zero
//   undefined -> rsp_zero tied to 0, no zero-detect logic
//
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   req_valid/req_ready        : request handshake (ready only in IDLE)
//   req_op, req_len            : sequence op, word count minus one (saturated)
//   req_lhs, req_rhs           : little-endian operands, WIDTH*MAX_BYTES bits
//   alu_operation, alu_lhs/rhs : registered opcode and operand word to the ALU
//   alu_assert_n               : active-low ALU bus assert (low only in ISSUE)
//   alu_result, alu_flag_carry : ALU result word and carry, sampled in CAPTURE
//   rsp_valid/rsp_ready        : response handshake
//   rsp_data, rsp_carry, rsp_zero : result, final carry, zero flag
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BYTES = 4,
    localparam int LEN_W    = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [1:0]                   req_op,
    input  logic [LEN_W-1:0]             req_len,
    input  logic [WIDTH*MAX_BYTES-1:0]   req_lhs,
    input  logic [WIDTH*MAX_BYTES-1:0]   req_rhs,
    output logic [3:0]                   alu_operation,
    output logic [WIDTH-1:0]             alu_lhs,
    output logic [WIDTH-1:0]             alu_rhs,
    output logic                         alu_assert_n,
    input  logic [WIDTH-1:0]             alu_result,
    input  logic                         alu_flag_carry,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [WIDTH*MAX_BYTES-1:0]   rsp_data,
    output logic                         rsp_carry,
    output logic                         rsp_zero
);

    localparam int BUS_W = WIDTH * MAX_BYTES;
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_BYTES - 1);

    state_e           state;
    seq_op_e          op;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] index;
    logic [BUS_W-1:0] lhs;
    logic [BUS_W-1:0] rhs;
    logic [LEN_W-1:0] index_next;

    function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] l);
        return (l > LEN_MAX) ? LEN_MAX : l;
    endfunction

    function automatic logic [WIDTH-1:0] word_of(input logic [BUS_W-1:0] v,
                                                 input logic [LEN_W-1:0] i);
        return v[i*WIDTH +: WIDTH];
    endfunction

    assign index_next = LEN_W'(index + 1'b1);

    // ALU-facing outputs are registered, so each transition loads the values
    // the next state must present.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            req_ready     <= 1'b1;
            rsp_valid     <= 1'b0;
            rsp_data      <= '0;
            rsp_carry     <= 1'b0;
            index         <= '0;
            alu_assert_n  <= 1'b1;
            alu_operation <= ALU_NOP;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        op            <= seq_op_e'(req_op);
                        len           <= sat_len(req_len);
                        lhs           <= req_lhs;
                        rhs           <= req_rhs;
                        index         <= '0;
                        rsp_data      <= '0;
                        rsp_carry     <= 1'b0;
                        alu_lhs       <= req_lhs[WIDTH-1:0];
                        alu_rhs       <= req_rhs[WIDTH-1:0];
                        alu_operation <= first_opcode(seq_op_e'(req_op));
                        alu_assert_n  <= 1'b0;
                        req_ready     <= 1'b0;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    alu_assert_n  <= 1'b1;
                    alu_operation <= ALU_NOP;
                    state         <= CAPTURE;
                end
                CAPTURE: begin
                    rsp_data[index*WIDTH +: WIDTH] <= alu_result;
                    if (index == len) begin
                        rsp_carry <= op_keeps_carry(op) ? alu_flag_carry : 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        index         <= index_next;
                        alu_lhs       <= word_of(lhs, index_next);
                        alu_rhs       <= word_of(rhs, index_next);
                        alu_operation <= chain_opcode(op);
                        alu_assert_n  <= 1'b0;
                        state         <= ISSUE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_SEQ_ZERO_FLAG_EN
    // The word being written is still zero in rsp_data (cleared on accept),
    // so the whole-result test only needs the incoming word and the buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_zero <= 1'b0;
        end else if (state == IDLE && req_valid && req_ready) begin
            rsp_zero <= 1'b0;
        end else if (state == CAPTURE && index == len) begin
            rsp_zero <= (rsp_data == '0) && (alu_result == '0);
        end
    end
`else
    assign rsp_zero = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed bench for alu_seq with a registered single-word ALU model.
module tb_alu_seq;

    localparam int WIDTH     = 8;
    localparam int MAX_BYTES = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [1:0]  req_len;
    logic [31:0] req_lhs;
    logic [31:0] req_rhs;
    logic [3:0]  alu_operation;
    logic [7:0]  alu_lhs;
    logic [7:0]  alu_rhs;
    logic        alu_assert_n;
    logic [7:0]  alu_result = 8'h00;
    logic        alu_c = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_carry;
    logic        rsp_zero;

    int n_checks = 0;
    int n_fails  = 0;
    logic [3:0] ops [8];
    int nops;
    int lat;
    int vld_seen;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(WIDTH), .MAX_BYTES(MAX_BYTES)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_len(req_len), .req_lhs(req_lhs), .req_rhs(req_rhs),
        .alu_operation(alu_operation), .alu_lhs(alu_lhs), .alu_rhs(alu_rhs),
        .alu_assert_n(alu_assert_n), .alu_result(alu_result), .alu_flag_carry(alu_c),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero)
    );

    // External ALU: latches result and carry on an asserted bus cycle.
    // Opcodes: 0 NOP, 1 ADD, 2 ADC, 3 SUB, 4 SBC (carry = borrow), 5 AND, 6 XOR.
    logic [8:0] alu_t;
    always_comb begin
        alu_t = 9'h000;
        case (alu_operation)
            4'h1: alu_t = {1'b0, alu_lhs} + {1'b0, alu_rhs};
            4'h2: alu_t = {1'b0, alu_lhs} + {1'b0, alu_rhs} + {8'h00, alu_c};
            4'h3: alu_t = {1'b0, alu_lhs} - {1'b0, alu_rhs};
            4'h4: alu_t = {1'b0, alu_lhs} - {1'b0, alu_rhs} - {8'h00, alu_c};
            4'h5: alu_t = {1'b0, alu_lhs & alu_rhs};
            4'h6: alu_t = {1'b0, alu_lhs ^ alu_rhs};
            default: alu_t = 9'h000;
        endcase
    end

    always @(posedge clk) begin
        if (!alu_assert_n) begin
            alu_result <= alu_t[7:0];
            alu_c      <= alu_t[8];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called on a negedge with the DUT idle; returns on the negedge after accept.
    task automatic send(input logic [1:0] op, input logic [1:0] len,
                        input logic [31:0] l, input logic [31:0] r);
        req_op = op; req_len = len; req_lhs = l; req_rhs = r; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Counts cycles from the accept edge to the first rsp_valid, logging opcodes.
    task automatic wait_rsp(input string tag, output int cycles);
        cycles = 0;
        nops = 0;
        while (!rsp_valid && cycles < 40) begin
            if (!alu_assert_n && nops < 8) begin
                ops[nops] = alu_operation;
                nops++;
            end
            @(negedge clk);
            cycles++;
        end
        check($sformatf("%s_valid", tag), {63'd0, rsp_valid}, 64'd1);
    endtask

    logic exp_zero_b;
    logic [31:0] held;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef ALU_SEQ_ZERO_FLAG_EN
        exp_zero_b = 1'b1;
`else
        exp_zero_b = 1'b0;
`endif
        reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
        req_op = 2'd0; req_len = 2'd0; req_lhs = '0; req_rhs = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", {63'd0, req_ready}, 64'd1);
        check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst_rsp_data", {32'd0, rsp_data}, 64'd0);
        check("rst_rsp_carry", {63'd0, rsp_carry}, 64'd0);
        check("rst_rsp_zero", {63'd0, rsp_zero}, 64'd0);
        check("rst_assert_n", {63'd0, alu_assert_n}, 64'd1);
        check("rst_alu_op", {60'd0, alu_operation}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // ADD, 4 words: carry ripples from word 0 into word 1
        send(2'd0, 2'd3, 32'h0000_00FF, 32'h0000_0001);
        wait_rsp("add4", lat);
        check("add4_lat", 64'(lat), 64'd8);
        check("add4_data", {32'd0, rsp_data}, 64'h0000_0100);
        check("add4_carry", {63'd0, rsp_carry}, 64'd0);
        check("add4_zero", {63'd0, rsp_zero}, 64'd0);
        check("add4_nops", 64'(nops), 64'd4);
        check("add4_op0", {60'd0, ops[0]}, 64'h1);
        for (int i = 1; i < 4; i++)
            check($sformatf("add4_op%0d", i), {60'd0, ops[i]}, 64'h2);
        @(negedge clk);
        check("add4_back_idle", {63'd0, req_ready}, 64'd1);
        check("add4_rsp_drop", {63'd0, rsp_valid}, 64'd0);

        // ADD, 1 word with carry out and zero result
        send(2'd0, 2'd0, 32'h0000_00FF, 32'h0000_0001);
        wait_rsp("add1", lat);
        check("add1_lat", 64'(lat), 64'd2);
        check("add1_data", {32'd0, rsp_data}, 64'h0);
        check("add1_carry", {63'd0, rsp_carry}, 64'd1);
        check("add1_zero", {63'd0, rsp_zero}, {63'd0, exp_zero_b});
        @(negedge clk);

        // AND, 4 words: fills upper words so the next short op shows clearing
        send(2'd2, 2'd3, 32'hF0F0_F0F0, 32'hFFFF_0000);
        wait_rsp("and4", lat);
        check("and4_lat", 64'(lat), 64'd8);
        check("and4_data", {32'd0, rsp_data}, 64'hF0F0_0000);
        check("and4_carry", {63'd0, rsp_carry}, 64'd0);
        @(negedge clk);

        // ADD, 2 words: words above len must read zero
        send(2'd0, 2'd1, 32'hAABB_1122, 32'h1111_0101);
        wait_rsp("add2", lat);
        check("add2_lat", 64'(lat), 64'd4);
        check("add2_data", {32'd0, rsp_data}, 64'h0000_1223);
        check("add2_carry", {63'd0, rsp_carry}, 64'd0);
        @(negedge clk);

        // SUB, 1 word with borrow out
        send(2'd1, 2'd0, 32'h0000_0000, 32'h0000_0001);
        wait_rsp("sub1", lat);
        check("sub1_data", {32'd0, rsp_data}, 64'h0000_00FF);
        check("sub1_carry", {63'd0, rsp_carry}, 64'd1);
        check("sub1_zero", {63'd0, rsp_zero}, 64'd0);
        @(negedge clk);

        // SUB, 2 words with response back-pressure and a waiting XOR request
        rsp_ready = 1'b0;
        send(2'd1, 2'd1, 32'h0000_0100, 32'h0000_0001);
        req_op = 2'd3; req_len = 2'd0; req_lhs = 32'h0000_000F; req_rhs = 32'h0000_00F0;
        req_valid = 1'b1;
        wait_rsp("sub2", lat);
        check("sub2_lat", 64'(lat), 64'd4);
        check("sub2_data", {32'd0, rsp_data}, 64'h0000_00FF);
        check("sub2_carry", {63'd0, rsp_carry}, 64'd0);
        held = rsp_data;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("hold%0d_valid", i), {63'd0, rsp_valid}, 64'd1);
            check($sformatf("hold%0d_data", i), {32'd0, rsp_data}, {32'd0, held});
            check($sformatf("hold%0d_carry", i), {63'd0, rsp_carry}, 64'd0);
            check($sformatf("hold%0d_ready", i), {63'd0, req_ready}, 64'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("b2b_idle_ready", {63'd0, req_ready}, 64'd1);
        check("b2b_idle_valid", {63'd0, rsp_valid}, 64'd0);
        @(negedge clk);
        req_valid = 1'b0;
        check("b2b_accepted", {63'd0, req_ready}, 64'd0);
        wait_rsp("xor1", lat);
        check("xor1_lat", 64'(lat), 64'd2);
        check("xor1_data", {32'd0, rsp_data}, 64'h0000_00FF);
        check("xor1_carry", {63'd0, rsp_carry}, 64'd0);
        @(negedge clk);

        // Reset during the second CAPTURE of a 4-word request
        send(2'd0, 2'd3, 32'h0403_0201, 32'h0101_0101);
        repeat (3) @(negedge clk);
        check("mid_capture_word0", {32'd0, rsp_data}, 64'h0000_0002);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_ready", {63'd0, req_ready}, 64'd1);
        check("mid_rst_valid", {63'd0, rsp_valid}, 64'd0);
        check("mid_rst_data", {32'd0, rsp_data}, 64'd0);
        check("mid_rst_carry", {63'd0, rsp_carry}, 64'd0);
        check("mid_rst_assert_n", {63'd0, alu_assert_n}, 64'd1);
        check("mid_rst_alu_op", {60'd0, alu_operation}, 64'd0);
        vld_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rsp_valid) vld_seen++;
        end
        check("mid_rst_no_rsp", 64'(vld_seen), 64'd0);
        check("mid_rst_still_idle", {63'd0, req_ready}, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
- REQ-001 SHALL have parameter WIDTH, default 8, ALU byte width.
- REQ-002 SHALL have parameter MAX_BYTES, default 4, maximum operand length in ALU words.
- REQ-003 SHALL have port clk, input, 1, single clock; all logic on rising edge.
- REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
- REQ-005 SHALL have req_valid, req_ready: input/output, 1 each; request handshake.
- REQ-006 SHALL have req_op, input, 2: sequence op (ADD, SUB, AND, XOR).
- REQ-007 SHALL have req_len, input, clog2(MAX_BYTES): word count minus one.
- REQ-008 SHALL have req_lhs and req_rhs, input, WIDTH*MAX_BYTES each: little-endian operands.
- REQ-009 SHALL have alu_operation, output, 4: opcode driven to the ALU.
- REQ-010 SHALL have alu_lhs and alu_rhs, output, WIDTH each: current operand words.
- REQ-011 SHALL have alu_assert_n, output, 1: active-low ALU bus assert.
- REQ-012 SHALL have alu_result, input, WIDTH, and alu_flag_carry, input, 1.
- REQ-013 SHALL have rsp_valid, rsp_ready: output/input, 1 each; response handshake.
- REQ-014 SHALL have rsp_data (output, WIDTH*MAX_BYTES), rsp_carry (output, 1) and rsp_zero (output, 1).

Function
- REQ-015 SHALL use states IDLE, ISSUE, CAPTURE, DONE.
- REQ-016 SHALL assert req_ready only in IDLE; accept on req_valid&&req_ready; latch op, len, operands; clear index and result buffer; go to ISSUE.
- REQ-017 SHALL in ISSUE drive word[index] of both operands, alu_assert_n=0, and alu_operation = FIRST opcode when index==0, else CHAIN (carry-propagating) opcode; go to CAPTURE.
- REQ-018 SHALL in CAPTURE write alu_result into rsp_data word[index]; if index==len capture alu_flag_carry into rsp_carry and go to DONE, else increment index and return to ISSUE.
- REQ-019 SHALL drive alu_assert_n=1 and alu_operation=NOP in IDLE, CAPTURE, DONE.
- REQ-020 SHALL assert rsp_valid only in DONE and hold rsp_data/rsp_carry/rsp_zero stable until rsp_valid&&rsp_ready, then return to IDLE.
- REQ-021 SHALL take exactly 2*(len+1) cycles from accept to first rsp_valid cycle.
- REQ-022 SHALL leave rsp_data words above len as zero.
- REQ-023 SHALL ignore req_valid outside IDLE; a new request is accepted no earlier than the cycle after the response handshake.
- REQ-024 SHALL treat req_len >= MAX_BYTES as MAX_BYTES-1 (saturate).
- REQ-025 SHALL force rsp_carry to 0 for AND and XOR.

Reset
- REQ-026 SHALL on reset (including mid-operation) enter IDLE next edge, with req_ready=1, rsp_valid=0, rsp_data=0, rsp_carry=0, rsp_zero=0, index=0, alu_assert_n=1, alu_operation=NOP.
- REQ-027 SHALL discard any in-flight request on reset with no response.

Configuration
- REQ-028 SHALL honour macro ALU_SEQ_ZERO_FLAG_EN: when defined, rsp_zero=1 iff all captured words 0..len are zero; when undefined, rsp_zero tied 0 and no zero logic synthesized.

Structure
- REQ-029 SHALL place sequence-op enum, state enum, NOP opcode and FIRST/CHAIN opcode table per sequence op in shared package alu_seq_pkg.
- REQ-030 SHALL implement as one module; no sub-module required.

Verification
- REQ-031 ADD len=3, lhs=0x000000FF, rhs=0x00000001 -> rsp_data=0x00000100, rsp_carry=0, rsp_valid after 8 cycles; alu_operation FIRST then CHAIN x3.
- REQ-032 ADD len=0, lhs=0xFF, rhs=0x01 -> rsp_data=0x00, rsp_carry=1, rsp_zero=1 (macro defined), 0 (undefined), latency 2.
- REQ-033 SUB len=1, lhs=0x0100, rhs=0x0001 -> rsp_data=0x00FF; rsp_ready held low 5 cycles -> outputs stable, req_ready=0 throughout.
- REQ-034 Reset asserted in second CAPTURE of len=3 request -> next cycle IDLE, req_ready=1, rsp_valid never asserted, rsp_data=0.
- REQ-035 Back-to-back requests with req_valid held high and rsp_ready=1 -> second accepted the cycle after first response handshake; results independent (no carry leakage: XOR 0x0F^0xF0 -> 0xFF, rsp_carry=0).
